// File: rtl/seven_segment_scanner_if.sv
// Value-load bus between system logic and the seven-segment scanner.
// The master drives display data, strobe and live brightness; the scanner is the slave.
interface seven_segment_scanner_if #(
   parameter int unsigned NUM_DIGITS = 8,
   parameter int unsigned BRIGHT_W   = 4
);
   logic [4*NUM_DIGITS-1:0] val_in;
   logic                    val_valid_in;
   logic [NUM_DIGITS-1:0]   dp_in;
   logic [NUM_DIGITS-1:0]   blank_in;
   logic [BRIGHT_W-1:0]     brightness_in;

   modport master (
      output val_in,
      output val_valid_in,
      output dp_in,
      output blank_in,
      output brightness_in
   );

   modport slave (
      input val_in,
      input val_valid_in,
      input dp_in,
      input blank_in,
      input brightness_in
   );
endinterface

// File: rtl/seven_segment_scanner.sv
// Multiplexed seven-segment driver: digit scan, PWM dimming, tear-free shadow/commit update.
// Optional SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN darkens digits above the top nonzero nibble.
module seven_segment_scanner #(
   parameter int unsigned NUM_DIGITS   = 8,
   parameter int unsigned COUNT_PERIOD = 100000,
   parameter int unsigned BRIGHT_W     = 4
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   seven_segment_scanner_if.slave  bus,
   output logic [6:0]              cat_out,
   output logic                    dp_out,
   output logic [NUM_DIGITS-1:0]   an_out,
   output logic                    frame_done_out
);
   localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned CntW = $clog2(COUNT_PERIOD);
   localparam int unsigned ValW = 4 * NUM_DIGITS;
   localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_DIGITS - 1);
   localparam logic [CntW-1:0] LastCnt = CntW'(COUNT_PERIOD - 1);

   typedef struct packed {
      logic [ValW-1:0]       val;
      logic [NUM_DIGITS-1:0] dp;
      logic [NUM_DIGITS-1:0] blank;
   } frame_t;

   logic [IdxW-1:0]       idx_q, idx_d;
   logic [CntW-1:0]       dwell_q, dwell_d;
   logic [BRIGHT_W-1:0]   pwm_q, pwm_d;
   frame_t                shadow_q, shadow_d;
   frame_t                disp_q, disp_d;
   logic                  pending_q, pending_d;
   logic [NUM_DIGITS-1:0] an_q, an_d;
   logic [6:0]            cat_q, cat_d;
   logic                  dpo_q, dpo_d;

   logic                  wrap;
   logic                  pwm_on;
   logic                  digit_on;
   logic [3:0]            nibble;
   logic [NUM_DIGITS-1:0] lz_blank;
   logic [NUM_DIGITS-1:0] blank_eff;
   frame_t                incoming;

   function automatic logic [6:0] hex_decode(input logic [3:0] n);
      logic [6:0] seg;
      case (n)
         4'h0: seg = 7'h3F;
         4'h1: seg = 7'h06;
         4'h2: seg = 7'h5B;
         4'h3: seg = 7'h4F;
         4'h4: seg = 7'h66;
         4'h5: seg = 7'h6D;
         4'h6: seg = 7'h7D;
         4'h7: seg = 7'h07;
         4'h8: seg = 7'h7F;
         4'h9: seg = 7'h6F;
         4'hA: seg = 7'h77;
         4'hB: seg = 7'h7C;
         4'hC: seg = 7'h39;
         4'hD: seg = 7'h5E;
         4'hE: seg = 7'h79;
         default: seg = 7'h71;
      endcase
      return seg;
   endfunction

   assign wrap           = (dwell_q == LastCnt) && (idx_q == LastIdx);
   assign frame_done_out = wrap;
   assign incoming       = '{val: bus.val_in, dp: bus.dp_in, blank: bus.blank_in};

`ifdef SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN
   logic seen_nonzero;
   always_comb begin
      seen_nonzero = 1'b0;
      lz_blank     = '0;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         if (disp_q.val[4*k +: 4] != 4'h0) seen_nonzero = 1'b1;
         // Digit 0 stays lit so a zero value still shows a single "0".
         if (k != 0) lz_blank[k] = ~seen_nonzero;
      end
   end
`else
   assign lz_blank = '0;
`endif

   assign blank_eff = disp_q.blank | lz_blank;

   // Scan counters.
   always_comb begin
      pwm_d   = pwm_q + 1'b1;
      dwell_d = dwell_q + 1'b1;
      idx_d   = idx_q;
      if (dwell_q == LastCnt) begin
         dwell_d = '0;
         idx_d   = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
      end
   end

   // A strobe on the wrap cycle bypasses the shadow so it shows from the next digit-0 slot.
   always_comb begin
      shadow_d  = shadow_q;
      pending_d = pending_q;
      disp_d    = disp_q;
      if (bus.val_valid_in) shadow_d = incoming;
      if (wrap) begin
         if (bus.val_valid_in) begin
            disp_d = incoming;
         end else if (pending_q) begin
            disp_d = shadow_q;
         end
         pending_d = 1'b0;
      end else if (bus.val_valid_in) begin
         pending_d = 1'b1;
      end
   end

   always_comb begin
      pwm_on   = (&bus.brightness_in) || (pwm_q < bus.brightness_in);
      nibble   = disp_q.val[{idx_q, 2'b00} +: 4];
      digit_on = pwm_on && !blank_eff[idx_q];
      an_d     = '1;
      cat_d    = 7'h7F;
      dpo_d    = 1'b1;
      if (digit_on) begin
         an_d  = ~(NUM_DIGITS'(1) << idx_q);
         cat_d = ~hex_decode(nibble);
         dpo_d = ~disp_q.dp[idx_q];
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         idx_q     <= '0;
         dwell_q   <= '0;
         pwm_q     <= '0;
         shadow_q  <= '0;
         disp_q    <= '0;
         pending_q <= 1'b0;
         an_q      <= '1;
         cat_q     <= 7'h7F;
         dpo_q     <= 1'b1;
      end else begin
         idx_q     <= idx_d;
         dwell_q   <= dwell_d;
         pwm_q     <= pwm_d;
         shadow_q  <= shadow_d;
         disp_q    <= disp_d;
         pending_q <= pending_d;
         an_q      <= an_d;
         cat_q     <= cat_d;
         dpo_q     <= dpo_d;
      end
   end

   assign an_out  = an_q;
   assign cat_out = cat_q;
   assign dp_out  = dpo_q;
endmodule

// File: tb/tb_seven_segment_scanner.sv
// Randomized bench for seven_segment_scanner against a time-based reference model.
// The model honours SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN when the build defines it.
module tb_seven_segment_scanner;
   localparam int unsigned N  = 4;
   localparam int unsigned P  = 3;
   localparam int unsigned BW = 4;
   localparam int unsigned FRAME = N * P;

   logic         clk = 1'b0;
   logic         rst;
   logic [6:0]   cat;
   logic         dp;
   logic [N-1:0] an;
   logic         fd;

   always #5 clk = ~clk;

   seven_segment_scanner_if #(.NUM_DIGITS(N), .BRIGHT_W(BW)) bus ();

   seven_segment_scanner #(
      .NUM_DIGITS  (N),
      .COUNT_PERIOD(P),
      .BRIGHT_W    (BW)
   ) dut (
      .clk_in        (clk),
      .rst_in        (rst),
      .bus           (bus.slave),
      .cat_out       (cat),
      .dp_out        (dp),
      .an_out        (an),
      .frame_done_out(fd)
   );

   logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   int n_cmp = 0;
   int n_bad = 0;

   // Model: t = cycles since reset; the frame shows the latest data strobed before it began.
   int unsigned  t;
   logic [15:0]  m_val;
   logic [N-1:0] m_dp, m_blank;
   logic [15:0]  nx_val;
   logic [N-1:0] nx_dp, nx_blank;
   bit           nx_have;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0d, time %0t)", tag, got, exp, t, $time);
      end
   endtask

   // Called at a negedge with inputs set; advances one clock and checks the pins.
   task automatic cycle();
      logic [N-1:0] e_an;
      logic [6:0]   e_cat;
      logic         e_dp;
      int           dig;
      int           top;
      bit           lit;
      e_an  = '1;
      e_cat = 7'h7F;
      e_dp  = 1'b1;
      if (rst) begin
         t = 0;
         m_val = '0; m_dp = '0; m_blank = '0;
         nx_val = '0; nx_dp = '0; nx_blank = '0; nx_have = 0;
      end else begin
         dig = int'((t / P) % N);
         lit = (bus.brightness_in == 4'hF) || ((t % 16) < bus.brightness_in);
         if (m_blank[dig]) lit = 0;
`ifdef SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN
         top = 0;
         for (int k = 0; k < int'(N); k++) if (m_val[4*k +: 4] != 4'h0) top = k;
         if (dig > top) lit = 0;
`else
         top = int'(N) - 1;
`endif
         if (lit) begin
            e_an  = ~(N'(1) << dig);
            e_cat = ~seg_tab[m_val[4*dig +: 4]];
            e_dp  = ~m_dp[dig];
         end
         if (bus.val_valid_in) begin
            nx_val = bus.val_in; nx_dp = bus.dp_in; nx_blank = bus.blank_in; nx_have = 1;
         end
         if ((t % FRAME) == FRAME - 1 && nx_have) begin
            m_val = nx_val; m_dp = nx_dp; m_blank = nx_blank; nx_have = 0;
         end
         t++;
      end
      @(negedge clk);
      check_value("an_out", 32'(an), 32'(e_an));
      check_value("cat_out", 32'(cat), 32'(e_cat));
      check_value("dp_out", 32'(dp), 32'(e_dp));
      check_value("frame_done", 32'(fd), 32'((t % FRAME) == FRAME - 1));
   endtask

   task automatic strobe(input logic [15:0] v, input logic [N-1:0] d, input logic [N-1:0] b);
      bus.val_in = v; bus.dp_in = d; bus.blank_in = b; bus.val_valid_in = 1'b1;
      cycle();
      bus.val_valid_in = 1'b0;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   initial begin
      logic [15:0] mask;
      rst = 1'b1;
      bus.val_in = '0; bus.dp_in = '0; bus.blank_in = '0; bus.val_valid_in = 1'b0;
      bus.brightness_in = 4'hF;
      run(3);
      rst = 1'b0;
      run(30);

      // Mid-frame strobe, then a strobe exactly on the wrap cycle.
      while ((t % FRAME) != 5) cycle();
      strobe(16'hF8A1, '0, '0);
      run(30);
      while ((t % FRAME) != FRAME - 1) cycle();
      strobe(16'h1234, '0, '0);
      run(24);

      bus.brightness_in = 4'h0; run(40);
      bus.brightness_in = 4'h4; run(40);
      bus.brightness_in = 4'hF; run(20);

      strobe(16'h9876, 4'b0001, 4'b0100); run(30);
      strobe(16'h0050, '0, '0); run(30);
      strobe(16'h0000, '0, '0); run(30);

      while ((t % FRAME) != 7) cycle();
      rst = 1'b1; cycle(); rst = 1'b0;
      run(15);

      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 5) == 0) begin
            case ($urandom_range(0, 4))
               0: mask = 16'h0000;
               1: mask = 16'h000F;
               2: mask = 16'h00FF;
               3: mask = 16'h0FFF;
               default: mask = 16'hFFFF;
            endcase
            bus.val_in       = 16'($urandom) & mask;
            bus.dp_in        = N'($urandom);
            bus.blank_in     = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
            bus.val_valid_in = 1'b1;
         end else begin
            bus.val_valid_in = 1'b0;
         end
         if ($urandom_range(0, 39) == 0) bus.brightness_in = BW'($urandom);
         rst = ($urandom_range(0, 149) == 0);
         cycle();
      end
      rst = 1'b0;
      bus.val_valid_in = 1'b0;
      run(12);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
